lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the RV32I execute stage and a single-port data-memory bus with a req/gnt/rvalid handshake.
- Accepts one LOAD_S or STORE_S operation at a time.
- Checks alignment and funct3, generates byte enables and shifts write data.
- Sequences the bus transaction; aligns and sign- or zero-extends load data.
- Returns a single-cycle response with destination register and error flag.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 16, WAIT-state cycles before a timeout error; used only with LSU_TIMEOUT_EN.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  core presents an operation
req_ready_o  output  1  LSU can accept an operation (high only in IDLE)
req_we_i  input  1  1 = store, 0 = load
req_funct3_i  input  3  funct3_Type_LOAD or funct3_Type_STORE encoding
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data, right-aligned
req_rd_i  input  5  load destination register
resp_valid_o  output  1  one-cycle response strobe
resp_rdata_o  output  DATA_WIDTH  extended load data (0 for stores and errors)
resp_rd_o  output  5  destination echo (0 for stores)
resp_err_o  output  2  0 = ok, 1 = misaligned, 2 = bus error, 3 = illegal funct3 or timeout
mem_req_o  output  1  bus request
mem_gnt_i  input  1  bus grant
mem_we_o  output  1  bus write
mem_be_o  output  4  byte enables
mem_addr_o  output  ADDR_WIDTH  word-aligned address ([1:0] = 0)
mem_wdata_o  output  DATA_WIDTH  lane-shifted store data
mem_rvalid_i  input  1  bus response valid
mem_rdata_i  input  DATA_WIDTH  bus read data
mem_err_i  input  1  bus error, sampled with rvalid
busy_o  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: FSM = IDLE; all outputs = 0 except req_ready_o = 1. Reset mid-operation drops mem_req_o the next cycle; a later stray mem_rvalid_i in IDLE is ignored.
- Accept: a request is accepted on a cycle where req_valid_i && req_ready_o. All request fields are registered on accept.
- Checks on accept:
  - Illegal funct3: load funct3 011, 110 or 111; store funct3 >= 011.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Illegal funct3 takes priority over misaligned.
  - Either error goes straight to RESP with the error code; no bus access.
- States:
  - IDLE -> REQ on a good accept; IDLE -> RESP on an error accept.
  - REQ: mem_req_o = 1, with address, we, be and wdata held stable until mem_gnt_i. REQ -> WAIT on gnt.
  - WAIT: mem_req_o = 0. WAIT -> RESP on mem_rvalid_i; rdata and err are captured then.
  - RESP: resp_valid_o = 1 for exactly one cycle. RESP -> IDLE.
- Latency: with gnt in the first REQ cycle and rvalid on the next cycle, the response appears 3 cycles after accept.
- Bus response timing: rvalid in the same cycle as gnt is not legal. The bus delivers rvalid at least one cycle after gnt.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
  - Store data is replicated across lanes: byte x4, half x2.
- Load extraction: select the byte or half at addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- Bus error: mem_err_i with rvalid gives resp_err_o = 2 and resp_rdata_o = 0.
- Stores also complete on rvalid; this ensures ordering.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no rvalid, the FSM goes to RESP with err = 3. A late rvalid arriving in IDLE is ignored.
- Undefined: no counter is present and WAIT holds indefinitely.

Decomposition:
- The shared riscv_definitions package gains:
  - lsu_state_e {IDLE, REQ, WAIT, RESP}.
  - lsu_err_e {LSU_OK, LSU_MISALIGN, LSU_BUSERR, LSU_ILLEGAL}.
- The package's existing funct3 enums are used for decode.
- One combinational sub-module, lsu_align, handles byte-enable generation, write-lane replication, read extraction and extension, and misalignment and illegal-funct3 detection. The FSM stays in lsu_ctrl.

Test Plan:
- LW addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> mem_be 1111, mem_addr 0x100; resp_rdata 0xDEADBEEF and err 0 at accept+3.
- LB addr 0x203, rdata 0x80FF_FF7F -> be 1000, resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x12, wdata 0x0000_ABCD, gnt delayed 4 cycles -> mem_req, addr 0x10, be 1100 and wdata 0xABCDABCD held stable for all 4 cycles. Response has err 0 and rd 0.
- LW addr 0x102 -> no mem_req_o ever asserted; resp_err 1 one cycle after accept. Load funct3 011 -> resp_err 3.
- rvalid with mem_err_i = 1 -> resp_err 2 and rdata 0. Reset asserted in WAIT -> mem_req_o 0 and req_ready_o 1 next cycle; a subsequent rvalid produces no resp_valid_o.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 16, rvalid withheld -> resp_err 3 after 16 WAIT cycles, then a new request is accepted normally.

Source files
------------

// File: rtl/riscv_definitions.sv
// Shared RV32I definitions: funct3 encodings for loads/stores and the LSU state/error types.
package riscv_definitions;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_Type_LOAD;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } funct3_Type_STORE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_OK       = 2'd0,
        LSU_MISALIGN = 2'd1,
        LSU_BUSERR   = 2'd2,
        LSU_ILLEGAL  = 2'd3
    } lsu_err_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store lane replication,
// load extraction/extension, and misalignment / illegal-funct3 detection.
module lsu_align
    import riscv_definitions::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_lanes,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  misalign,
    output logic                  illegal
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[8*addr_lo +: 8];
    assign rd_half = rdata[16*addr_lo[1] +: 16];

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = '0;
        misalign    = 1'b0;
        if (we)
            illegal = (funct3 >= 3'b011);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                be          = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
                misalign    = addr_lo[0];
            end
            2'b10: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                misalign    = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            LB:      rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            LBU:     rdata_ext = {24'h000000, rd_byte};
            LH:      rdata_ext = {{16{rd_half[15]}}, rd_half};
            LHU:     rdata_ext = {16'h0000, rd_half};
            LW:      rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer driving a req/gnt/rvalid data bus.
// Define LSU_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | bus request held until grant
// WAIT  | granted, waiting for rvalid (or timeout)
// RESP  | one-cycle response to the core
module lsu_ctrl
    import riscv_definitions::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [4:0]            resp_rd_o,
    output logic [1:0]            resp_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  busy_o
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lsu_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
    end

    lsu_state_e            state, state_nxt;
    logic                  op_we;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [4:0]            op_rd;
    lsu_err_e              err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  idle, accept;
    logic                  al_we, al_misalign, al_illegal;
    logic [2:0]            al_funct3;
    logic [1:0]            al_addr_lo;
    logic [DATA_WIDTH-1:0] al_wdata, al_wdata_lanes, al_rdata_ext;
    logic [3:0]            al_be;

    assign idle   = (state == IDLE);
    assign accept = idle && req_valid_i;

    // In IDLE the aligner checks the incoming request; afterwards it works on the held operation.
    assign al_we      = idle ? req_we_i          : op_we;
    assign al_funct3  = idle ? req_funct3_i      : op_funct3;
    assign al_addr_lo = idle ? req_addr_i[1:0]   : op_addr[1:0];
    assign al_wdata   = idle ? req_wdata_i       : op_wdata;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .we          (al_we),
        .funct3      (al_funct3),
        .addr_lo     (al_addr_lo),
        .wdata       (al_wdata),
        .rdata       (mem_rdata_i),
        .be          (al_be),
        .wdata_lanes (al_wdata_lanes),
        .rdata_ext   (al_rdata_ext),
        .misalign    (al_misalign),
        .illegal     (al_illegal)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == REQ && mem_gnt_i)
            tmo_cnt <= '0;
        else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid_i) state_nxt = (al_illegal || al_misalign) ? RESP : REQ;
            REQ:  if (mem_gnt_i) state_nxt = WAIT;
            WAIT: begin
                if (mem_rvalid_i) state_nxt = RESP;
`ifdef LSU_TIMEOUT_EN
                else if (tmo_hit) state_nxt = RESP;
`endif
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_rd_o    = 5'd0;
        resp_err_o   = 2'd0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = op_we;
                mem_be_o    = al_be;
                mem_addr_o  = {op_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_o = al_wdata_lanes;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = rdata_q;
                resp_rd_o    = op_we ? 5'd0 : op_rd;
                resp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_rd     <= 5'd0;
            err_q     <= LSU_OK;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                op_we     <= req_we_i;
                op_funct3 <= req_funct3_i;
                op_addr   <= req_addr_i;
                op_wdata  <= req_wdata_i;
                op_rd     <= req_rd_i;
                rdata_q   <= '0;
                if (al_illegal)
                    err_q <= LSU_ILLEGAL;
                else if (al_misalign)
                    err_q <= LSU_MISALIGN;
                else
                    err_q <= LSU_OK;
            end
            if (state == WAIT) begin
                if (mem_rvalid_i) begin
                    err_q   <= mem_err_i ? LSU_BUSERR : LSU_OK;
                    rdata_q <= (mem_err_i || op_we) ? '0 : al_rdata_ext;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_q   <= LSU_ILLEGAL;
                    rdata_q <= '0;
                end
`endif
            end
        end
    end

endmodule
